// File: rtl/box_mover.sv
// Bouncing-box position generator: advances a box once per frame, reflects it off
// the visible-area edges and accepts PAUSE/RESUME/STEP/REVERSE commands.
module box_mover #(
   parameter int HD    = 640,
   parameter int VD    = 480,
   parameter int BOX_W = 16,
   parameter int BOX_H = 10,
   parameter int STEP  = 1
) (
   input  logic       clk_25MHz,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_data,
   output logic       cmd_ready,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic       bounce,
   output logic [7:0] bounce_count,
   output logic       running
);

   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_PAUSED     = 2'd1;
   localparam logic [1:0] ST_STEP_ARMED = 2'd2;

   localparam logic [1:0] CMD_PAUSE   = 2'd0;
   localparam logic [1:0] CMD_RESUME  = 2'd1;
   localparam logic [1:0] CMD_STEP    = 2'd2;
   localparam logic [1:0] CMD_REVERSE = 2'd3;

   localparam logic [10:0] XMAX   = 11'(HD - 1 - BOX_W);
   localparam logic [10:0] YMAX   = 11'(VD - 1 - BOX_H);
   localparam logic [10:0] STEP_W = 11'(STEP);

   logic [1:0]       state_q, state_d;
   logic             pending_q, pending_d;
   logic [1:0][9:0]  pos_q, pos_d, pos_upd;
   logic [1:0]       dir_q, dir_d, flip;
   logic             bounce_q, bounce_d;
   logic [7:0]       count_q, count_d;

   // Index 0 is the X axis, index 1 the Y axis; both follow the same clamp-and-reflect rule.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_axis
         localparam logic [10:0] LIMIT = (gi == 0) ? XMAX : YMAX;
         logic [10:0] cur;
         logic [10:0] sum;
         logic [9:0]  upd;
         logic        flp;

         assign cur = {1'b0, pos_q[gi]};
         assign sum = cur + STEP_W;

         always_comb begin
            upd = pos_q[gi];
            flp = 1'b0;
            if (dir_q[gi]) begin
               if (sum >= LIMIT) begin
                  upd = LIMIT[9:0];
                  flp = 1'b1;
               end else begin
                  upd = sum[9:0];
               end
            end else begin
               if (cur <= STEP_W) begin
                  upd = 10'd0;
                  flp = 1'b1;
               end else begin
                  upd = 10'(cur - STEP_W);
               end
            end
         end

         assign pos_upd[gi] = upd;
         assign flip[gi]    = flp;
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      pos_d     = pos_q;
      dir_d     = dir_q;
      bounce_d  = 1'b0;
      count_d   = count_q;
      if (pending_q) begin
         // Update cycle: commands are held off by cmd_ready, a tick here is ignored.
         pending_d = 1'b0;
         pos_d     = pos_upd;
         dir_d     = dir_q ^ flip;
         bounce_d  = |flip;
         if ((|flip) && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
         end
         if (state_q == ST_STEP_ARMED) begin
            state_d = ST_PAUSED;
         end
      end else begin
         if (frame_tick && (state_q != ST_PAUSED)) begin
            pending_d = 1'b1;
         end
         if (cmd_valid) begin
            case (cmd_data)
               CMD_PAUSE:   state_d = ST_PAUSED;
               CMD_RESUME:  state_d = ST_RUN;
               CMD_STEP:    if (state_q == ST_PAUSED) state_d = ST_STEP_ARMED;
               CMD_REVERSE: dir_d = ~dir_q;
               default:     state_d = state_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk_25MHz) begin
      if (reset) begin
         state_q   <= ST_RUN;
         pending_q <= 1'b0;
         pos_q[0]  <= 10'd100;
         pos_q[1]  <= 10'd150;
         dir_q     <= 2'b11;
         bounce_q  <= 1'b0;
         count_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         pos_q     <= pos_d;
         dir_q     <= dir_d;
         bounce_q  <= bounce_d;
         count_q   <= count_d;
      end
   end

   assign cmd_ready    = ~pending_q;
   assign pos_x        = pos_q[0];
   assign pos_y        = pos_q[1];
   assign dir_x        = dir_q[0];
   assign dir_y        = dir_q[1];
   assign bounce       = bounce_q;
   assign bounce_count = count_q;
   assign running      = (state_q == ST_RUN);

endmodule

// File: tb/tb_box_mover.sv
// Bench for box_mover: a stimulus table plus model-driven sequences feed a scoreboard
// queue; a second, smaller instance is used to reach an exact corner hit.
module tb_box_mover;

   localparam int XMAX = 623;
   localparam int YMAX = 469;
   localparam int STEPV = 1;
   localparam logic [1:0] C_PAUSE = 2'd0, C_RESUME = 2'd1, C_STEP = 2'd2, C_REV = 2'd3;

   typedef struct {
      logic       r, t, v;
      logic [1:0] d;
      int         px, py;
      logic       dx, dy, run, rdy, bnc;
      int         cnt;
   } vec_t;

   typedef struct {
      int    px, py;
      logic  dx, dy, run, rdy, bnc;
      int    cnt;
      string tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, frame_tick, cmd_valid;
   logic [1:0] cmd_data;
   logic       cmd_ready, dir_x, dir_y, bounce, running;
   logic [9:0] pos_x, pos_y;
   logic [7:0] bounce_count;

   logic       alt_tick, alt_cmd_valid, alt_cmd_ready, alt_dir_x, alt_dir_y, alt_bounce, alt_running;
   logic [1:0] alt_cmd_data;
   logic [9:0] alt_pos_x, alt_pos_y;
   logic [7:0] alt_bounce_count;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t sb_q[$];
   vec_t tab[$];

   int m_state, m_pend, m_x, m_y, m_dx, m_dy, m_bnc, m_cnt;

   always #20 clk = ~clk;

   box_mover u_dut (
      .clk_25MHz(clk), .reset(reset), .frame_tick(frame_tick),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .pos_x(pos_x), .pos_y(pos_y), .dir_x(dir_x), .dir_y(dir_y),
      .bounce(bounce), .bounce_count(bounce_count), .running(running)
   );

   // XMAX=200, YMAX=225: from (100,150) the box reaches (1,1) moving up-left after 299 updates.
   box_mover #(.HD(217), .VD(236)) u_alt (
      .clk_25MHz(clk), .reset(reset), .frame_tick(alt_tick),
      .cmd_valid(alt_cmd_valid), .cmd_data(alt_cmd_data), .cmd_ready(alt_cmd_ready),
      .pos_x(alt_pos_x), .pos_y(alt_pos_y), .dir_x(alt_dir_x), .dir_y(alt_dir_y),
      .bounce(alt_bounce), .bounce_count(alt_bounce_count), .running(alt_running)
   );

   function automatic vec_t mk(input logic r, t, v, input logic [1:0] d, input int px, py,
                               input logic dx, dy, run, rdy, bnc, input int cnt);
      vec_t x;
      x.r = r; x.t = t; x.v = v; x.d = d; x.px = px; x.py = py;
      x.dx = dx; x.dy = dy; x.run = run; x.rdy = rdy; x.bnc = bnc; x.cnt = cnt;
      return x;
   endfunction

   task automatic axis(input int p, input int d, input int lim, output int np, output int nd, output int fl);
      np = p; nd = d; fl = 0;
      if (d != 0) begin
         np = p + STEPV;
         if (np >= lim) begin np = lim; nd = 0; fl = 1; end
      end else begin
         np = p - STEPV;
         if (np <= 0) begin np = 0; nd = 1; fl = 1; end
      end
   endtask

   task automatic model_step(input logic r, t, v, input logic [1:0] d);
      int nx, ny, ndx, ndy, fx, fy;
      if (r) begin
         m_state = 0; m_pend = 0; m_x = 100; m_y = 150; m_dx = 1; m_dy = 1; m_bnc = 0; m_cnt = 0;
      end else if (m_pend != 0) begin
         axis(m_x, m_dx, XMAX, nx, ndx, fx);
         axis(m_y, m_dy, YMAX, ny, ndy, fy);
         m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
         m_bnc = (fx != 0 || fy != 0) ? 1 : 0;
         if (m_bnc != 0 && m_cnt < 255) m_cnt++;
         if (m_state == 2) m_state = 1;
         m_pend = 0;
      end else begin
         m_bnc = 0;
         if (t && m_state != 1) m_pend = 1;
         if (v) begin
            case (d)
               C_PAUSE:  m_state = 1;
               C_RESUME: m_state = 0;
               C_STEP:   if (m_state == 1) m_state = 2;
               default:  begin m_dx = 1 - m_dx; m_dy = 1 - m_dy; end
            endcase
         end
      end
   endtask

   task automatic sb_check();
      exp_t e;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL sb_empty: no expected record for this cycle");
         return;
      end
      e = sb_q.pop_front();
      if (int'(pos_x) != e.px || int'(pos_y) != e.py || dir_x !== e.dx || dir_y !== e.dy ||
          running !== e.run || cmd_ready !== e.rdy || bounce !== e.bnc || int'(bounce_count) != e.cnt) begin
         n_fail++;
         $display("FAIL %s: got x=%0d y=%0d dx=%b dy=%b run=%b rdy=%b bnc=%b cnt=%0d, want x=%0d y=%0d dx=%b dy=%b run=%b rdy=%b bnc=%b cnt=%0d",
                  e.tag, pos_x, pos_y, dir_x, dir_y, running, cmd_ready, bounce, bounce_count,
                  e.px, e.py, e.dx, e.dy, e.run, e.rdy, e.bnc, e.cnt);
      end
   endtask

   task automatic apply(input logic r, t, v, input logic [1:0] d);
      reset = r; frame_tick = t; cmd_valid = v; cmd_data = d;
      model_step(r, t, v, d);
   endtask

   task automatic drive_vec(input vec_t x, input int idx);
      exp_t e;
      apply(x.r, x.t, x.v, x.d);
      e.px = x.px; e.py = x.py; e.dx = x.dx; e.dy = x.dy; e.run = x.run;
      e.rdy = x.rdy; e.bnc = x.bnc; e.cnt = x.cnt; e.tag = $sformatf("row%0d", idx);
      sb_q.push_back(e);
      @(posedge clk); #1;
      sb_check();
   endtask

   task automatic drive_cycle(input logic r, t, v, input logic [1:0] d);
      exp_t e;
      apply(r, t, v, d);
      e.px = m_x; e.py = m_y; e.dx = (m_dx != 0); e.dy = (m_dy != 0); e.run = (m_state == 0);
      e.rdy = (m_pend == 0); e.bnc = (m_bnc != 0); e.cnt = m_cnt; e.tag = "model";
      sb_q.push_back(e);
      @(posedge clk); #1;
      sb_check();
   endtask

   task automatic tick_cycle();
      drive_cycle(1'b0, 1'b1, 1'b0, 2'd0);
      drive_cycle(1'b0, 1'b0, 1'b0, 2'd0);
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; cmd_valid = 1'b0; cmd_data = 2'd0;
      alt_tick = 1'b0; alt_cmd_valid = 1'b0; alt_cmd_data = 2'd0;
      m_state = 0; m_pend = 0; m_x = 100; m_y = 150; m_dx = 1; m_dy = 1; m_bnc = 0; m_cnt = 0;

      //                r  t  v  cmd       px   py  dx dy run rdy bnc cnt
      tab.push_back(mk(1, 0, 0, C_PAUSE,  100, 150, 1, 1, 1, 1, 0, 0));
      tab.push_back(mk(1, 1, 1, C_PAUSE,  100, 150, 1, 1, 1, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, C_PAUSE,  100, 150, 1, 1, 1, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, C_PAUSE,  101, 151, 1, 1, 1, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, C_PAUSE,  101, 151, 1, 1, 1, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, C_PAUSE,  102, 152, 1, 1, 1, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, C_PAUSE,  102, 152, 1, 1, 1, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, C_PAUSE,  103, 153, 1, 1, 1, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, C_PAUSE,  103, 153, 1, 1, 1, 0, 0, 0));
      tab.push_back(mk(0, 0, 1, C_REV,    104, 154, 1, 1, 1, 1, 0, 0));
      tab.push_back(mk(0, 0, 1, C_REV,    104, 154, 0, 0, 1, 1, 0, 0));
      tab.push_back(mk(0, 0, 0, C_PAUSE,  104, 154, 0, 0, 1, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, C_PAUSE,  104, 154, 0, 0, 1, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, C_PAUSE,  103, 153, 0, 0, 1, 1, 0, 0));
      tab.push_back(mk(0, 0, 1, C_PAUSE,  103, 153, 0, 0, 0, 1, 0, 0));
      for (int i = 0; i < 5; i++)
         tab.push_back(mk(0, 1, 0, C_PAUSE, 103, 153, 0, 0, 0, 1, 0, 0));
      tab.push_back(mk(0, 0, 1, C_STEP,   103, 153, 0, 0, 0, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, C_PAUSE,  103, 153, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 1, 0, C_PAUSE,  102, 152, 0, 0, 0, 1, 0, 0));
      tab.push_back(mk(0, 0, 0, C_PAUSE,  102, 152, 0, 0, 0, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, C_PAUSE,  102, 152, 0, 0, 0, 1, 0, 0));
      tab.push_back(mk(0, 0, 1, C_RESUME, 102, 152, 0, 0, 1, 1, 0, 0));
      tab.push_back(mk(0, 0, 1, C_STEP,   102, 152, 0, 0, 1, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, C_PAUSE,  102, 152, 0, 0, 1, 0, 0, 0));
      tab.push_back(mk(1, 0, 0, C_PAUSE,  100, 150, 1, 1, 1, 1, 0, 0));
      tab.push_back(mk(0, 0, 0, C_PAUSE,  100, 150, 1, 1, 1, 1, 0, 0));

      for (int i = 0; i < tab.size(); i++) drive_vec(tab[i], i);

      // Run right until x sits one pixel from the right wall.
      for (int n = 0; n < 2000 && !(m_x == XMAX - 1 && m_dx == 1); n++) tick_cycle();
      chk("pre_edge_x", int'(pos_x), 622);
      chk("pre_edge_dir", int'(dir_x), 1);
      tick_cycle();
      chk("edge_x", int'(pos_x), 623);
      chk("edge_dir", int'(dir_x), 0);
      chk("edge_bounce", int'(bounce), 1);
      drive_cycle(1'b0, 1'b0, 1'b0, 2'd0);
      chk("edge_bounce_end", int'(bounce), 0);
      tick_cycle();
      chk("after_edge_x", int'(pos_x), 622);

      // Each REVERSE+tick drives x back into the wall: one forced bounce per pass.
      for (int i = 0; i < 300; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b1, C_REV);
         tick_cycle();
      end
      chk("sat_count", int'(bounce_count), 255);

      drive_cycle(1'b0, 1'b1, 1'b0, 2'd0);
      chk("pend_ready", int'(cmd_ready), 0);
      drive_cycle(1'b1, 1'b0, 1'b0, 2'd0);
      chk("rst_pend_x", int'(pos_x), 100);
      chk("rst_pend_y", int'(pos_y), 150);
      drive_cycle(1'b0, 1'b0, 1'b0, 2'd0);
      chk("rst_pend_x_late", int'(pos_x), 100);
      chk("rst_pend_cnt", int'(bounce_count), 0);

      for (int i = 0; i < 299; i++) begin
         alt_tick = 1'b1;
         drive_cycle(1'b0, 1'b0, 1'b0, 2'd0);
         alt_tick = 1'b0;
         drive_cycle(1'b0, 1'b0, 1'b0, 2'd0);
      end
      chk("corner_pre_x", int'(alt_pos_x), 1);
      chk("corner_pre_y", int'(alt_pos_y), 1);
      chk("corner_pre_dirs", int'({alt_dir_x, alt_dir_y}), 0);
      chk("corner_pre_cnt", int'(alt_bounce_count), 2);
      alt_tick = 1'b1;
      drive_cycle(1'b0, 1'b0, 1'b0, 2'd0);
      alt_tick = 1'b0;
      drive_cycle(1'b0, 1'b0, 1'b0, 2'd0);
      chk("corner_x", int'(alt_pos_x), 0);
      chk("corner_y", int'(alt_pos_y), 0);
      chk("corner_dirs", int'({alt_dir_x, alt_dir_y}), 3);
      chk("corner_bounce", int'(alt_bounce), 1);
      chk("corner_cnt", int'(alt_bounce_count), 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/box_mover.md
BOX_MOVER -- requirements
Module: box_mover

Interface
REQ-001 The block SHALL have parameter HD, default 640, meaning visible width in pixels.
REQ-002 The block SHALL have parameter VD, default 480, meaning visible height in lines.
REQ-003 The block SHALL have parameter BOX_W, default 16, meaning box width minus one.
REQ-004 The block SHALL have parameter BOX_H, default 10, meaning box height minus one.
REQ-005 The block SHALL have parameter STEP, default 1, meaning pixels moved per axis per update, range 1..15.
REQ-006 The block SHALL have port clk_25MHz, input, 1 bit: pixel clock.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse at counter origin (x=0, y=0).
REQ-009 The block SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-010 The block SHALL have port cmd_data, input, 2 bits: 00 PAUSE, 01 RESUME, 10 STEP, 11 REVERSE.
REQ-011 The block SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-012 The block SHALL have port pos_x, output, 10 bits: box left edge, registered.
REQ-013 The block SHALL have port pos_y, output, 10 bits: box top edge, registered.
REQ-014 The block SHALL have port dir_x, output, 1 bit: 1 = moving right, 0 = moving left.
REQ-015 The block SHALL have port dir_y, output, 1 bit: 1 = moving down, 0 = moving up.
REQ-016 The block SHALL have port bounce, output, 1 bit: one-cycle pulse on an update that flips any direction.
REQ-017 The block SHALL have port bounce_count, output, 8 bits: total bounces, saturating.
REQ-018 The block SHALL have port running, output, 1 bit: high when in state RUN.

Function
REQ-019 The block SHALL define XMAX = HD-1-BOX_W (623 at defaults) and YMAX = VD-1-BOX_H (469 at defaults).
REQ-020 The block SHALL implement states RUN, PAUSED and STEP_ARMED, plus a one-bit pending flag.
REQ-021 In RUN or STEP_ARMED, frame_tick high on edge N SHALL set pending; positions SHALL update on edge N+1, and pending SHALL clear on edge N+1.
REQ-022 In PAUSED, frame_tick SHALL be ignored.
REQ-023 cmd_ready SHALL equal NOT pending, so no command is accepted in an update cycle.
REQ-024 Transition PAUSE: RUN or STEP_ARMED SHALL go to PAUSED; PAUSED SHALL stay PAUSED.
REQ-025 Transition RESUME: any state SHALL go to RUN.
REQ-026 Transition STEP: PAUSED SHALL go to STEP_ARMED; STEP in RUN or STEP_ARMED SHALL be a no-op.
REQ-027 A position update completed from STEP_ARMED SHALL return the block to PAUSED on the same edge.
REQ-028 REVERSE SHALL invert dir_x and dir_y on the accept edge without changing state or position, and SHALL NOT pulse bounce.
REQ-029 X update, moving right: nx = min(pos_x+STEP, XMAX); if nx == XMAX, dir_x SHALL flip to 0.
REQ-030 X update, moving left: if pos_x <= STEP then nx = 0 and dir_x SHALL flip to 1; otherwise nx = pos_x-STEP.
REQ-031 The Y update SHALL follow the X rules using YMAX and dir_y.
REQ-032 Arithmetic SHALL be at least 11 bits wide so that no intermediate wraps.
REQ-033 bounce SHALL be high for exactly the update edge's following cycle when either axis flips; a corner hit SHALL count as one bounce.
REQ-034 bounce_count SHALL increment by 1 per bounce and SHALL hold at 255.
REQ-035 running SHALL be 1 exactly when the state is RUN.

Reset
REQ-036 On reset, the block SHALL set pos_x=100, pos_y=150, dir_x=1, dir_y=1, state=RUN, pending=0, bounce=0, bounce_count=0, running=1, cmd_ready=1.
REQ-037 Reset SHALL override frame_tick and cmd_valid on the same edge.
REQ-038 Reset while pending SHALL cancel the update.

Verification
REQ-039 The bench SHALL cover: after reset, 3 frame_ticks -> pos (103,153) with bounce never high.
REQ-040 The bench SHALL cover: pos_x=622, dir_x=1, STEP=1, tick -> pos_x=623, dir_x=0, bounce pulses once, and the next tick gives pos_x=622.
REQ-041 The bench SHALL cover: pos=(0+1,0+1) moving up-left, tick -> (0,0), both dirs flip to 1, bounce_count +1 (not +2).
REQ-042 The bench SHALL cover: PAUSE, 5 ticks -> pos unchanged; STEP then 2 ticks -> exactly one update and the state returns to PAUSED (running=0).
REQ-043 The bench SHALL cover: cmd_valid held on the cycle after a tick -> cmd_ready=0 there and the command is accepted one cycle later; REVERSE flips dirs with bounce=0.
REQ-044 The bench SHALL cover: 300 forced bounces -> bounce_count=255; reset asserted on the pending cycle -> position = (100,150) with no update applied.
